// File: rtl/adc_frame_ctrl.sv
// XADC capture sequencer: paced conversion starts, ping-pong sample banks,
// per-bank ready flags with CPU acknowledge, and sticky error reporting.
module adc_frame_ctrl #(
  parameter int CLK_DIV     = 3125,
  parameter int FRAME_LEN   = 256,
  parameter int TIMEOUT_CYC = 255,
  localparam int AW = $clog2(FRAME_LEN)
) (
  input  logic          sys_clk_in,
  input  logic          sys_rst_n,
  input  logic          en,
  output logic          adc_convst,
  input  logic          adc_eoc,
  input  logic [15:0]   adc_do,
  output logic [1:0]    frame_rdy,
  output logic          irq,
  input  logic [1:0]    frame_ack,
  output logic          wr_bank,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [11:0]   rd_data,
  output logic          overrun,
  output logic          timeout_err,
  input  logic          clr_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, CONV, WAIT_EOC, STORE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] idx;
  logic [11:0]   sample;
  logic [11:0]   mem [2][FRAME_LEN];

  logic       tick, lost_tick, store_wr, store_drop, wrap, timeout_hit;
  logic [1:0] set_mask;
  logic       unused_lsb;

  assign unused_lsb  = ^adc_do[3:0];
  assign tick        = en && (cnt == CW'(CLK_DIV - 1));
  assign lost_tick   = tick && (state inside {CONV, WAIT_EOC, STORE});
  assign store_wr    = (state == STORE) && !frame_rdy[wr_bank];
  assign store_drop  = (state == STORE) && frame_rdy[wr_bank];
  assign wrap        = store_wr && (idx == AW'(FRAME_LEN - 1));
  assign timeout_hit = (state == WAIT_EOC) && !adc_eoc && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign set_mask    = wrap ? (2'b01 << wr_bank) : 2'b00;

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt <= '0;
    else if (!en || cnt == CW'(CLK_DIV - 1)) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      adc_convst  <= 1'b0;
      to_cnt      <= '0;
      idx         <= '0;
      sample      <= '0;
      wr_bank     <= 1'b0;
      frame_rdy   <= 2'b00;
      irq         <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      adc_convst  <= 1'b0;
      irq         <= |frame_rdy;
      frame_rdy   <= (frame_rdy & ~frame_ack) | set_mask;
      // error set beats a simultaneous clear
      overrun     <= (overrun & ~clr_err) | lost_tick | store_drop;
      timeout_err <= (timeout_err & ~clr_err) | timeout_hit;
      case (state)
        IDLE: if (en) state <= WAIT_TICK;
        WAIT_TICK: begin
          if (!en) begin
            state <= IDLE;
            idx   <= '0;
          end else if (tick) begin
            state      <= CONV;
            adc_convst <= 1'b1;
          end
        end
        CONV: begin
          state  <= WAIT_EOC;
          to_cnt <= '0;
        end
        WAIT_EOC: begin
          if (adc_eoc) begin
            sample <= adc_do[15:4];
            state  <= STORE;
          end else if (timeout_hit) begin
            state <= en ? WAIT_TICK : IDLE;
            if (!en) idx <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        STORE: begin
          if (store_wr) begin
            if (wrap) begin
              idx     <= '0;
              wr_bank <= ~wr_bank;
            end else begin
              idx <= idx + AW'(1);
            end
          end
          // leaving capture discards any partial frame
          if (!en) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            state <= WAIT_TICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_in) begin
    if (store_wr) mem[wr_bank][idx] <= sample;
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) rd_data <= '0;
    else rd_data <= mem[rd_bank][rd_addr];
  end
endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Directed bench for adc_frame_ctrl with a small ADC responder model and
// a table of bank read-back vectors.
module tb_adc_frame_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic        adc_convst, adc_eoc = 1'b0;
  logic [15:0] adc_do = '0;
  logic [1:0]  frame_rdy, frame_ack = 2'b00;
  logic        irq, wr_bank, rd_bank = 1'b0, overrun, timeout_err, clr_err = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [11:0] rd_data;

  int  checks = 0, errors = 0;
  int  n = 0, d = 0;
  logic withhold = 1'b0;

  typedef struct { logic bank; logic [1:0] addr; logic [11:0] exp; } rd_vec_t;
  rd_vec_t tbl [13];

  adc_frame_ctrl #(.CLK_DIV(8), .FRAME_LEN(4), .TIMEOUT_CYC(16)) dut (
    .sys_clk_in(clk), .sys_rst_n(rst_n), .en(en), .adc_convst(adc_convst),
    .adc_eoc(adc_eoc), .adc_do(adc_do), .frame_rdy(frame_rdy), .irq(irq),
    .frame_ack(frame_ack), .wr_bank(wr_bank), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data(rd_data), .overrun(overrun), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // ADC responder: eoc three cycles after convst, sample value 0x123 + n
  always @(negedge clk) begin
    if (!rst_n) begin
      d = 0; adc_eoc = 1'b0; n = 0;
    end else begin
      adc_eoc = 1'b0;
      if (d > 0) begin
        d = d - 1;
        if (d == 0 && !withhold) begin
          adc_do  = 16'h1230 + 16'(n << 4);
          adc_eoc = 1'b1;
          n = n + 1;
        end
      end
      if (adc_convst) d = 3;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_convst"}, 32'(adc_convst), 0);
    chk({tag, "_frame_rdy"}, 32'(frame_rdy), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; frame_ack = 2'b00; clr_err = 1'b0; withhold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      rd_bank = tbl[i].bank; rd_addr = tbl[i].addr;
      @(negedge clk);
      chk($sformatf("rd_vec%0d", i), 32'(rd_data), 32'(tbl[i].exp));
    end
  endtask

  task automatic wait_convst(input int maxc, output int t);
    t = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (adc_convst) begin t = i; break; end
    end
  endtask

  task automatic wait_rdy(input logic [1:0] mask, input string name);
    logic hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((frame_rdy & mask) == mask) begin hit = 1'b1; break; end
    end
    chk(name, 32'(hit), 1);
  endtask

  initial begin
    int t, cv, nxt;
    logic hit;
    for (int i = 0; i < 4; i++) begin
      tbl[i]   = '{1'b0, 2'(i), 12'h123 + 12'(i)};
      tbl[i+4] = '{1'b1, 2'(i), 12'h127 + 12'(i)};
      tbl[i+9] = '{1'b0, 2'(i), 12'h126 + 12'(i)};
    end
    tbl[8] = '{1'b0, 2'd2, 12'h125};

    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // capture two frames, read them back, acknowledge
    @(negedge clk); en = 1'b1;
    wait_convst(40, t);
    chk("first_convst_latency", 32'(t), 8);
    wait_rdy(2'b01, "t1_bank0_ready");
    repeat (2) @(negedge clk);
    chk("t1_frame_rdy", 32'(frame_rdy), 32'h1);
    chk("t1_irq", 32'(irq), 1);
    chk("t1_wr_bank", 32'(wr_bank), 1);
    read_range(0, 3);
    wait_rdy(2'b10, "t2_bank1_ready");
    chk("t2_both_ready", 32'(frame_rdy), 32'h3);
    frame_ack = 2'b01; @(negedge clk); frame_ack = 2'b00;
    chk("t2_ack0_rdy", 32'(frame_rdy), 32'h2);
    chk("t2_ack0_irq", 32'(irq), 1);
    frame_ack = 2'b01; @(negedge clk); frame_ack = 2'b00;
    chk("t2_ack_not_ready", 32'(frame_rdy), 32'h2);
    frame_ack = 2'b10; @(negedge clk); frame_ack = 2'b00;
    chk("t2_ack1_rdy", 32'(frame_rdy), 32'h0);
    chk("t2_irq_lag", 32'(irq), 1);
    @(negedge clk);
    chk("t2_irq_clear", 32'(irq), 0);
    chk("t2_no_overrun", 32'(overrun), 0);
    read_range(4, 7);

    // both banks full: ninth sample dropped
    do_reset();
    @(negedge clk); en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (overrun) begin hit = 1'b1; break; end
    end
    en = 1'b0;
    chk("t3_overrun_seen", 32'(hit), 1);
    chk("t3_drop_on_9th", 32'(n), 9);
    chk("t3_both_ready", 32'(frame_rdy), 32'h3);
    chk("t3_wr_bank", 32'(wr_bank), 0);
    read_range(0, 7);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t3_clr_overrun", 32'(overrun), 0);

    // withheld eoc: timeout, then next start on the following tick
    do_reset();
    withhold = 1'b1;
    @(negedge clk); en = 1'b1;
    wait_convst(40, t);
    chk("t4_first_convst", 32'(t), 8);
    nxt = 0; cv = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 16) chk("t4_te_before", 32'(timeout_err), 0);
      if (i == 17) chk("t4_te_set", 32'(timeout_err), 1);
      if (adc_convst) begin cv++; if (nxt == 0) nxt = i; end
    end
    chk("t4_next_convst", 32'(nxt), 24);
    chk("t4_convst_count", 32'(cv), 1);
    chk("t4_lost_tick_overrun", 32'(overrun), 1);
    @(negedge clk); clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t4_clr_te", 32'(timeout_err), 0);
    chk("t4_clr_ovr", 32'(overrun), 0);

    // en drops with a conversion in flight
    do_reset();
    @(negedge clk); en = 1'b1;
    cv = 0;
    for (int i = 0; i < 100 && cv < 3; i++) begin
      @(negedge clk);
      if (adc_convst) cv++;
    end
    en = 1'b0;
    chk("t5_third_convst", 32'(cv), 3);
    cv = 0;
    repeat (16) begin @(negedge clk); if (adc_convst) cv++; end
    chk("t5_idle_no_convst", 32'(cv), 0);
    chk("t5_in_flight_stored", 32'(n), 3);
    chk("t5_not_ready", 32'(frame_rdy), 0);
    read_range(8, 8);
    en = 1'b1;
    wait_rdy(2'b01, "t5_refill_ready");
    chk("t5_four_new_samples", 32'(n), 7);
    chk("t5_wr_bank", 32'(wr_bank), 1);
    read_range(9, 12);

    // asynchronous reset during WAIT_EOC
    wait_convst(40, t);
    chk("t6_convst_seen", 32'(t > 0), 1);
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cv = 0;
    repeat (12) begin @(negedge clk); if (adc_convst) cv++; end
    chk("t6_no_convst_without_en", 32'(cv), 0);
    en = 1'b1;
    wait_convst(40, t);
    chk("t6_convst_latency", 32'(t), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
